// File: rtl/sine_lookup_arbiter.sv
// sine_lookup_arbiter: round-robin time-sharing of one sine lookup among NUM_REQ requesters, tagged responses
module sine_lookup_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int LUT_LATENCY = 3,
  parameter int ADDR_W      = 11,
  parameter int DATA_W      = 17,
  parameter int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [ADDR_W-1:0]         lut_addr,
  input  logic signed [DATA_W-1:0]  lut_data,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic signed [DATA_W-1:0]  rsp_data,
  output logic [ID_W-1:0]           rsp_id,
  output logic                      busy
);
  logic [NUM_REQ-1:0] pend_q, pend_d, acc;
  logic [ADDR_W-1:0] paddr_q [NUM_REQ];
  logic [ID_W-1:0] rr_q, g;
  logic gv;
  logic [LUT_LATENCY:0] tv_q;
  logic [ID_W-1:0] tid_q [LUT_LATENCY+1];
  logic [ADDR_W-1:0] lut_addr_q;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic signed [DATA_W-1:0] rsp_data_q;
  logic [ID_W-1:0] rsp_id_q;
  logic busy_q;
  assign acc = req_valid & ~pend_q;
  always_comb begin
    gv = 1'b0;
    g = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (pend_q[(int'(rr_q) + k) % NUM_REQ]) begin
        gv = 1'b1;
        g = ID_W'((int'(rr_q) + k) % NUM_REQ);
      end
    end
    pend_d = (pend_q & ~(gv ? NUM_REQ'(1) << g : '0)) | acc;
  end
  // stage 0 of the tag pipe is loaded together with lut_addr; stage LUT_LATENCY lines up with lut_data
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= '0;
      rr_q <= '0;
      tv_q <= '0;
      lut_addr_q <= '0;
      rsp_valid_q <= '0;
      rsp_data_q <= '0;
      rsp_id_q <= '0;
      busy_q <= 1'b0;
      for (int i = 0; i <= LUT_LATENCY; i++) tid_q[i] <= '0;
      for (int i = 0; i < NUM_REQ; i++) paddr_q[i] <= '0;
    end else begin
      pend_q <= pend_d;
      for (int i = 0; i < NUM_REQ; i++) if (acc[i]) paddr_q[i] <= req_addr[i*ADDR_W +: ADDR_W];
      if (gv) begin
        lut_addr_q <= paddr_q[g];
        rr_q <= ID_W'((int'(g) + 1) % NUM_REQ);
      end
      tv_q <= {tv_q[LUT_LATENCY-1:0], gv};
      tid_q[0] <= g;
      for (int i = 1; i <= LUT_LATENCY; i++) tid_q[i] <= tid_q[i-1];
      rsp_valid_q <= tv_q[LUT_LATENCY] ? NUM_REQ'(1) << tid_q[LUT_LATENCY] : '0;
      if (tv_q[LUT_LATENCY]) begin
        rsp_data_q <= lut_data;
        rsp_id_q <= tid_q[LUT_LATENCY];
      end
      busy_q <= |pend_d | gv | |tv_q;
    end
  end
  assign req_ready = ~pend_q;
  assign lut_addr = lut_addr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data = rsp_data_q;
  assign rsp_id = rsp_id_q;
  assign busy = busy_q;
endmodule
